// File: rtl/yutorina_if_stage_pkg.sv
// Shared Yutorina CPU definitions used by the instruction fetch stage.
package yutorina_if_stage_pkg;

  localparam int YUTORINA_PC_W       = 30;
  localparam int YUTORINA_SPM_ADDR_W = 12;
  localparam int YUTORINA_WORD_W     = 32;

  typedef logic [YUTORINA_PC_W-1:0]       YutorinaPcBus;
  typedef logic [YUTORINA_WORD_W-1:0]     YutorinaWordDataBus;
  typedef logic [YUTORINA_SPM_ADDR_W-1:0] YutorinaSpmAddressBus;

  localparam YutorinaPcBus YUTORINA_RESET_VECTOR = '0;

  localparam logic YUTORINA_ENABLE_  = 1'b0;
  localparam logic YUTORINA_DISABLE_ = 1'b1;
  localparam logic YUTORINA_READ     = 1'b1;
  localparam logic YUTORINA_WRITE    = 1'b0;

endpackage

// File: rtl/yutorina_if_reg.sv
// IF/ID pipeline register: if_pc / if_en with reset > flush > stall priority.
module yutorina_if_reg #(
  parameter int PC_W = 30
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] new_pc,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] if_pc,
  output logic            if_en
);

  always_ff @(posedge clock) begin
    if (reset) begin
      if_pc <= '0;
      if_en <= 1'b0;
    end else if (flush) begin
      // redirect overwrites whatever was in flight
      if_pc <= new_pc;
      if_en <= 1'b1;
    end else if (!stall) begin
      if_pc <= pc;
      if_en <= 1'b1;
    end
  end

endmodule

// File: rtl/yutorina_if_stage.sv
// Yutorina instruction fetch stage: PC, SPM port A driver, IF/ID outputs.
// Optional retired-fetch counter enabled by YUTORINA_IF_FETCH_COUNTER_EN.
module yutorina_if_stage
  import yutorina_if_stage_pkg::*;
#(
  parameter int              PC_W         = YUTORINA_PC_W,
  parameter int              SPM_ADDR_W   = YUTORINA_SPM_ADDR_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = YUTORINA_RESET_VECTOR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PC_W-1:0]       new_pc,
  output logic [SPM_ADDR_W-1:0] spm_address,
  output logic                  spm_address_strobe_,
  output logic                  spm_read_write,
  output logic [31:0]           spm_write_data,
  input  logic [31:0]           spm_read_data,
  output logic [PC_W-1:0]       if_pc,
  output logic [31:0]           if_insn,
  output logic                  if_en,
  output logic [31:0]           fetch_count
);

  logic [PC_W-1:0] pc;

  always_ff @(posedge clock) begin
    if (reset)       pc <= RESET_VECTOR;
    else if (flush)  pc <= new_pc + PC_W'(1);
    else if (!stall) pc <= pc + PC_W'(1);
  end

  yutorina_if_reg #(.PC_W(PC_W)) u_if_reg (
    .clock  (clock),
    .reset  (reset),
    .stall  (stall),
    .flush  (flush),
    .new_pc (new_pc),
    .pc     (pc),
    .if_pc  (if_pc),
    .if_en  (if_en)
  );

  // On stall the held instruction is re-read so if_insn stays stable.
  always_comb begin
    spm_address = pc[SPM_ADDR_W-1:0];
    if (flush)      spm_address = new_pc[SPM_ADDR_W-1:0];
    else if (stall) spm_address = if_pc[SPM_ADDR_W-1:0];
  end

  assign spm_address_strobe_ = reset ? YUTORINA_DISABLE_ : YUTORINA_ENABLE_;
  assign spm_read_write      = YUTORINA_READ;
  assign spm_write_data      = '0;
  assign if_insn             = spm_read_data;

`ifdef YUTORINA_IF_FETCH_COUNTER_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clock) begin
    if (reset)                        fetch_count_q <= '0;
    else if (if_en && !stall && !flush) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: doc/yutorina_if_stage.md
# yutorina_if_stage

Instruction fetch stage of the Yutorina CPU. It owns the program counter and drives the instruction port (port A) of the scratch-pad memory (SPM) every cycle. It turns the SPM's one-cycle synchronous read data into the IF/ID pipeline outputs. It honours stall and flush requests from the pipeline control unit.

## Interface
Parameters:
- `PC_W`, default 30: width of the word program counter.
- `SPM_ADDR_W`, default 12: width of the SPM word address.
- `RESET_VECTOR`, default 0: the `PC_W`-bit word address fetched first after reset.

Ports:
- `clock`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the IF/ID outputs and the PC.
- `flush`  in  1  discard the instruction in flight and redirect fetch to `new_pc`.
- `new_pc`  in  `PC_W`  redirect target; sampled only when `flush`=1.
- `spm_address`  out  `SPM_ADDR_W`  SPM port A address.
- `spm_address_strobe_`  out  1  active-low access strobe.
- `spm_read_write`  out  1  always READ.
- `spm_write_data`  out  32  always 0.
- `spm_read_data`  in  32  SPM port A data, valid one cycle after its address.
- `if_pc`  out  `PC_W`  PC of the instruction presented to ID.
- `if_insn`  out  32  the fetched instruction.
- `if_en`  out  1  `if_insn` and `if_pc` are valid.
- `fetch_count`  out  32  count of retired fetches (see Configuration).

## Operation
- Registers: `pc` (next fetch address), `if_pc`, `if_en`, and the optional `fetch_count`.
- Outputs that are not registers:
  - `if_insn` = `spm_read_data`, passed through combinationally.
  - `spm_address` is a combinational mux:
    - `flush`=1: `new_pc[SPM_ADDR_W-1:0]`.
    - `stall`=1 (no flush): `if_pc[SPM_ADDR_W-1:0]`, so the SPM re-reads the held instruction.
    - otherwise: `pc[SPM_ADDR_W-1:0]`.
- Strobe and port constants:
  - `spm_address_strobe_` is ENABLE_ (0) whenever `reset`=0.
  - `spm_read_write` is always READ; `spm_write_data` is always 0.
- Per-edge update, highest priority first:
  - `reset`: `pc`←`RESET_VECTOR`, `if_pc`←0, `if_en`←0, `fetch_count`←0.
  - `flush` (wins over `stall`): `pc`←`new_pc`+1, `if_pc`←`new_pc`, `if_en`←1. The SPM was addressed with `new_pc` this cycle, so its data is valid next cycle. The instruction in flight is dropped by overwriting it.
  - `stall`: all registers hold.
  - otherwise: `if_pc`←`pc`, `pc`←`pc`+1, `if_en`←1.
- Arithmetic:
  - `pc`+1 is modulo 2^`PC_W`; all-ones wraps to 0.
  - SPM addressing uses only the low `SPM_ADDR_W` bits, which alias modulo the SPM size. There is no range fault.
- There is no state machine beyond the `if_en` valid bit. Stall-during-flush and flush-during-reset resolve strictly by the priority above.

## Timing
- Fetch-to-present latency is 1 cycle: an address driven in cycle N gives `if_insn` in cycle N+1.
- After `reset` deasserts at edge E:
  - cycle E: `spm_address`=`RESET_VECTOR`.
  - cycle E+1: `if_en`=1, `if_pc`=`RESET_VECTOR`.
  - throughput is then 1 instruction per cycle.
- Flush asserted in cycle N:
  - cycle N+1: `if_pc`=`new_pc`, with valid data.
  - exactly one bubble slot is lost, namely the instruction that would otherwise have appeared.
- Stall asserted for K cycles: outputs stay constant for K cycles. `if_insn` stays constant because the same address is re-read.
- Reset values: `if_en`=0, `if_pc`=0, `fetch_count`=0.
  - `spm_address_strobe_`=1 (disabled) while `reset`=1.
  - `if_insn` follows SPM data and is don't-care while `if_en`=0.

## Configuration
- Macro `YUTORINA_IF_FETCH_COUNTER_EN`.
- Defined: `fetch_count` increments on every edge where `if_en`=1, `stall`=0, `flush`=0 and `reset`=0. It wraps modulo 2^32.
- Undefined: no counter register is built; `fetch_count` is tied to 0. The port is present in both builds.

## Structure
- Shared CPU header holds:
  - `YutorinaPcBus`.
  - `YUTORINA_RESET_VECTOR`.
  - the existing `YutorinaWordDataBus`, `YutorinaSpmAddressBus`, `YUTORINA_ENABLE_`, `YUTORINA_READ`.
- One natural sub-module, `yutorina_if_reg`: the IF/ID pipeline register (`if_pc`/`if_en` with the reset/flush/stall priority). The PC, the address mux and the counter stay in the top level.

## Test plan
- Reset, then release with SPM[0..3]=A,B,C,D → `if_pc` 0,1,2,3 on consecutive cycles; `if_insn` A..D; `if_en` rises 1 cycle after release.
- Stall for 3 cycles while `if_pc`=2 → `if_pc`=2 and `if_insn`=C held for 3 cycles; `if_pc`=3 on the first cycle after stall.
- Flush with `new_pc`=0x100 while `if_pc`=1 → next cycle `if_pc`=0x100, `if_insn`=SPM[0x100]; then 0x101 follows.
- Flush and stall together with `new_pc`=0x20 → flush wins; next cycle `if_pc`=0x20.
- `pc`=2^30−1 → after it `if_pc`=0 (wrap); `spm_address` aliases to low 12 bits.
- Counter build: 5 free-running fetches, 2 stall cycles, 1 flush → `fetch_count`=5; reset mid-run → `fetch_count`=0, `if_en`=0 next cycle.
